input_debounce_capture: RTL and testbench

- Input-conditioning stage directly upstream of the priority-encoder / 7-segment decoder.
- Takes raw, asynchronous switch/button levels from the dedicated input pins.
- Synchronises and debounces each bit independently.
- Optionally holds ("sticky" capture) every bit that has been pressed, then presents a clean, glitch-free data word to the encoder's data input.

---
 rtl/input_debounce_capture.sv | 91 +++++++++
 tb/tb_input_debounce_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_capture.sv
// Input conditioning: 2-flop sync, per-bit debounce, sticky capture.
// Ports: clk, rst_n, ena, raw_in, latch_mode, clear -> data_out, change_pulse, any_active.
module input_debounce_capture #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             latch_mode,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             change_pulse,
    output logic             any_active
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            r_sync1;
    logic [WIDTH-1:0]            r_sync2;
    logic [WIDTH-1:0]            r_deb;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_sticky;
    logic [WIDTH-1:0]            r_dout;
    logic                        r_pulse;

    logic [WIDTH-1:0]            w_deb_nxt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]            w_rise;
    logic [WIDTH-1:0]            w_sticky_nxt;
    logic [WIDTH-1:0]            w_dout_nxt;

    // Per-bit debounce: count consecutive mismatching samples, accept
    // the new level on the terminal count, restart on any match.
    always_comb begin
        w_deb_nxt = r_deb;
        w_cnt_nxt = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (r_sync2[i] != r_deb[i]) begin
                if (r_cnt[i] == CNT_TERM) begin
                    w_deb_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press accepted in the same cycle as clear survives the clear.
    always_comb begin
        w_rise       = w_deb_nxt & ~r_deb;
        w_sticky_nxt = clear ? w_rise : (r_sticky | w_rise);
        w_dout_nxt   = latch_mode ? r_sticky : r_deb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb    <= '0;
            r_cnt    <= '0;
            r_sticky <= '0;
            r_dout   <= '0;
            r_pulse  <= 1'b0;
        end else if (ena) begin
            r_deb    <= w_deb_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sticky <= w_sticky_nxt;
            r_dout   <= w_dout_nxt;
            r_pulse  <= (w_dout_nxt != r_dout);
        end else begin
            r_pulse  <= 1'b0;
        end
    end

    assign data_out     = r_dout;
    assign change_pulse = r_pulse;
    assign any_active   = |r_dout;

endmodule

// File: tb/tb_input_debounce_capture.sv
// Randomised + directed bench for input_debounce_capture (DEBOUNCE_CYCLES=4).
// Reference model: windowed history of enabled sync samples.
module tb_input_debounce_capture;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] raw_in;
    logic         latch_mode;
    logic         clear;
    logic [W-1:0] data_out;
    logic         change_pulse;
    logic         any_active;

    int n_chk;
    int n_err;

    logic [W-1:0] m_s1, m_s2, m_deb, m_sticky, m_dout;
    logic         m_cp;
    logic [W-1:0] m_hist[$];

    input_debounce_capture #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .raw_in(raw_in),
        .latch_mode(latch_mode),
        .clear(clear),
        .data_out(data_out),
        .change_pulse(change_pulse),
        .any_active(any_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_deb = '0;
        m_sticky = '0; m_dout = '0; m_cp = 1'b0;
        m_hist.delete();
    endtask

    // Level flips once the last D enabled samples all disagree with it.
    task automatic model_step();
        logic [W-1:0] deb_n, rise;
        logic [W-1:0] dout_n;
        bit all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (ena) begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            deb_n = m_deb;
            if (m_hist.size() == D) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[k])
                        if (m_hist[k][b] == m_deb[b]) all_diff = 1'b0;
                    if (all_diff) deb_n[b] = ~m_deb[b];
                end
            end
            rise = deb_n & ~m_deb;
            dout_n = latch_mode ? m_sticky : m_deb;
            m_cp = (dout_n != m_dout);
            m_sticky = clear ? rise : (m_sticky | rise);
            m_deb = deb_n;
            m_dout = dout_n;
        end else begin
            m_cp = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = raw_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("dout", 32'(data_out), 32'(m_dout));
        chk("pulse", 32'(change_pulse), 32'(m_cp));
        chk("any", 32'(any_active), 32'(|m_dout));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges and check outputs clear at once.
    task automatic async_reset(input int hold);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("arst_dout", 32'(data_out), 32'h0);
        chk("arst_pulse", 32'(change_pulse), 32'h0);
        chk("arst_any", 32'(any_active), 32'h0);
        ticks(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        model_clear();
        rst_n = 1'b0;
        ena = 1'b1;
        raw_in = '0;
        latch_mode = 1'b0;
        clear = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        ticks(2);
        chk("rst_dout", 32'(data_out), 32'h0);
        chk("rst_pulse", 32'(change_pulse), 32'h0);

        // step to 0x81: visible exactly at edge 7
        raw_in = 8'h81;
        ticks(6);
        chk("lat6_dout", 32'(data_out), 32'h00);
        tick();
        chk("lat7_dout", 32'(data_out), 32'h81);
        chk("lat7_pulse", 32'(change_pulse), 32'h1);
        chk("lat7_any", 32'(any_active), 32'h1);
        tick();
        chk("lat8_pulse", 32'(change_pulse), 32'h0);
        raw_in = 8'h00;
        ticks(10);

        // bounce on bit3 is rejected
        for (int r = 0; r < 4; r++) begin
            raw_in = (r % 2 == 0) ? 8'h08 : 8'h00;
            ticks(2);
            chk("bounce_pulse", 32'(change_pulse), 32'h0);
        end
        ticks(8);
        chk("bounce_dout", 32'(data_out), 32'h00);
        raw_in = 8'h08;
        ticks(6);
        chk("b3_lat6", 32'(data_out), 32'h00);
        tick();
        chk("b3_lat7", 32'(data_out), 32'h08);
        ticks(3);
        raw_in = 8'h00;
        ticks(10);

        // sticky capture
        latch_mode = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ticks(3);
        chk("stk_clr", 32'(data_out), 32'h00);
        raw_in = 8'h04;
        ticks(8);
        raw_in = 8'h00;
        ticks(8);
        chk("stk_b2", 32'(data_out), 32'h04);
        raw_in = 8'h20;
        ticks(8);
        chk("stk_b5", 32'(data_out), 32'h24);
        raw_in = 8'h00;
        ticks(8);
        chk("stk_rel", 32'(data_out), 32'h24);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("stk_clr2", 32'(data_out), 32'h00);

        // clear coincident with bit0 acceptance
        raw_in = 8'h10;
        ticks(8);
        raw_in = 8'h00;
        ticks(8);
        chk("co_pre", 32'(data_out), 32'h10);
        raw_in = 8'h01;
        ticks(5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("co_dout", 32'(data_out), 32'h01);
        ticks(2);
        latch_mode = 1'b0;
        ticks(2);
        chk("lm_dout", 32'(data_out), 32'h01);
        chk("lm_pulse", 32'(change_pulse), 32'h0);
        raw_in = 8'h00;
        ticks(10);

        // ena freeze mid-count
        raw_in = 8'h40;
        ticks(4);
        ena = 1'b0;
        ticks(20);
        chk("frz_dout", 32'(data_out), 32'h00);
        ena = 1'b1;
        ticks(3);
        chk("frz_rel", 32'(data_out), 32'h40);

        // async reset from 0xFF
        raw_in = 8'hFF;
        ticks(10);
        chk("ff_dout", 32'(data_out), 32'hFF);
        async_reset(3);
        ticks(6);
        chk("rr_lat6", 32'(data_out), 32'h00);
        tick();
        chk("rr_lat7", 32'(data_out), 32'hFF);

        // randomised phase
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 11) == 0) raw_in[b] = ~raw_in[b];
            ena = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) latch_mode = ~latch_mode;
            clear = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) async_reset(2);
            else tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
